// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative MULT/MULTU/DIV/DIVU engine holding the
// architectural HI/LO registers. Operands are reduced to magnitudes on
// start, iterated one bit per cycle, then sign-corrected on the way into HI/LO.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nx;

    // acc holds {product} for multiply, {remainder, quotient} for divide
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw;     // dividend as sampled, returned on divide-by-zero
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [CNT_W-1:0]   cnt;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rsh;
    logic [WIDTH:0]     div_diff;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign op_signed = ~op[0];
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: IDLE -> CALC on start, CALC for WIDTH iterations, one FIX cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        div_rsh  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rsh - {1'b0, mcand};
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_rsh >= {1'b0, mcand}) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction of the magnitude result; divide-by-zero bypasses it
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div0     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // dividend (a) or multiplier (b) enters the low half of acc
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        mcand    <= op[1] ? b_mag : a_mag;
                        a_raw    <= a;
                        is_div   <= op[1];
                        neg_res  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= op_signed & a[WIDTH-1];
                        div_zero <= op[1] & (b == '0);
                        cnt      <= '0;
                        div0     <= 1'b0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    div0 <= div_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width and holds the results for MFHI/MFLO. It also accepts MTHI/MTLO writes. It sits beside the ALU, is started by the ALU-control decode of the R-type funct field, and stalls the pipeline through `busy` until results are valid.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a` in WIDTH: rs operand (multiplicand/dividend); sampled with `start`.
- `b` in WIDTH: rt operand (multiplier/divisor); sampled with `start`.
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wdata` in WIDTH: MTHI/MTLO data.
- `hi` out WIDTH: HI register (MFHI source).
- `lo` out WIDTH: LO register (MFLO source).
- `busy` out 1: operation in progress; the pipeline must stall MFHI/MFLO/MULT/DIV while it is high.
- `done` out 1: one-cycle pulse; `hi`/`lo` are new in this cycle.
- `div0` out 1: set with `done` when a DIV/DIVU had `b`==0; held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - On `start`=1: latch operands as magnitudes, using the absolute value for signed ops. Record the result sign and remainder sign. Clear the counter, clear `div0`, go to CALC.
  - On `start`=0: apply `hi_we`/`lo_we` from `wdata`. Both may write in the same cycle.
- **CALC**
  - One iteration per cycle for WIDTH cycles.
  - Multiply: shift-add radix-2 on a 2·WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - Leave for FIX when the counter reaches WIDTH-1.
- **FIX**
  - Apply sign correction (two's complement of the magnitude result).
  - Multiply: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - Divide: LO = quotient, HI = remainder.
  - Pulse `done`, return to IDLE.
- **Signed rules**
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / -1 gives LO = MIN and HI = 0 (two's complement wrap); no flag.
- **Divide by zero**
  - Full latency; LO = all ones, HI = `a` as sampled, `div0`=1.
  - The sign-correction step is skipped.
- **Start while busy:** `start` in CALC/FIX is ignored and not queued.
- **Writes while busy:** `hi_we`/`lo_we` in CALC/FIX are ignored.
- **Start with write:** `start` and `hi_we`/`lo_we` in the same IDLE cycle → `start` wins and the write is discarded.
- **Reset values:** `rst_n`=0 at any edge, including mid-CALC → state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div0`=0, counter=0. An operation in flight is abandoned.

## Timing
- E0 is the edge sampling `start`=1.
- `busy` is high in the cycles after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles; it is registered and derived from state != IDLE.
- `hi`/`lo` update at edge E(WIDTH+1). `done`=1 and `div0` are valid in the cycle after E(WIDTH+1); `busy` is 0 in that same cycle.
- A new `start` is accepted in the `done` cycle, so back-to-back issue has a WIDTH+2 cycle period.
- `hi`/`lo` are stable between updates.
- MTHI/MTLO take effect at the next edge.
- No combinational path from inputs to outputs.

## Test plan
- MULT a=FFFFFFFD (-3), b=00000007 → after 34 cycles: `done`, HI=FFFFFFFF, LO=FFFFFFEB. `busy` must be high for exactly 33 cycles.
- MULTU a=b=FFFFFFFF → HI=FFFFFFFE, LO=00000001. DIV a=FFFFFFF9 (-7), b=2 → LO=FFFFFFFD, HI=FFFFFFFF.
- DIV a=80000000, b=FFFFFFFF → LO=80000000, HI=00000000, `div0`=0. DIVU a=00000064, b=0 → LO=FFFFFFFF, HI=00000064, `div0`=1.
- MTHI 12345678 in IDLE → HI=12345678 next cycle. During busy, pulse `start` with new operands and pulse `lo_we` → both are ignored and the original result completes unchanged.
- Start MULTU, drive `rst_n`=0 for one edge mid-CALC (cycle 10) → all outputs 0 and no `done` pulse. A subsequent MULTU 6×7 gives HI=0, LO=0000002A.
- Assert `start` in the `done` cycle of a prior DIVU → accepted, with results for each operation correct in order.
